game_sequencer: RTL and testbench

Turn and scoring controller for the two-player VGA obstacle game. It owns the game state machine (idle, player 1 turn, player 2 turn, done) and the per-player scores. It gates the obstacle-shift and player-move datapath with enables and load/respawn pulses, and drives the status LEDs and seven-segment score digits. It sits between the clock divider / button logic and the row-shift and player-position registers.

---
 rtl/game_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
//   Turn and scoring controller for the two-player obstacle game. Owns the
//   game state machine and both scores, gates the obstacle-shift and
//   player-move datapath, and reports status.
//
// Ports
//   board_clk      in   system clock, rising edge
//   reset          in   asynchronous, active-high; clears every register
//   start          in   raw switch level, asynchronous to board_clk
//   tick           in   single-cycle game-rate strobe
//   hit            in   player overlaps an obstacle (synchronous level)
//   player_row     in   current player row index
//   state          out  00 idle, 01 player 1, 10 player 2, 11 done
//   p1_score       out  player 1 score, 0..WIN_SCORE
//   p2_score       out  player 2 score, 0..WIN_SCORE
//   winner         out  01 player 1 won, 10 player 2 won, else 00
//   obstacle_load  out  one-cycle pulse: reload obstacle pattern
//   player_reset   out  one-cycle pulse: return player to start cell
//   obstacle_step  out  one-cycle pulse: shift obstacle rows
//   player_en      out  button moves accepted (PLAY only)
//
// Every output is a flop; next values are computed in the FSM's
// combinational process and captured on the same edge as the state.
module game_sequencer #(
    parameter int WIN_SCORE    = 10,
    parameter int GOAL_ROW     = 1,
    parameter int TURN_TICKS   = 60,
    parameter int FREEZE_TICKS = 4
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    input  logic [3:0] player_row,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic       obstacle_load,
    output logic       player_reset,
    output logic       obstacle_step,
    output logic       player_en
);

    typedef enum logic [1:0] {IDLE, PLAY, FREEZE, DONE} fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic       turn_q, turn_d;
    logic [7:0] turn_cnt_q, turn_cnt_d;
    logic [3:0] freeze_cnt_q, freeze_cnt_d;
    logic [3:0] p1_d, p2_d;
    logic [1:0] winner_d, state_d;
    logic       load_d, preset_d, step_d;

    logic       start_s1, start_s2, start_dly;
    logic       start_rise, start_low, goal;
    logic [3:0] cur_score, cur_inc;

    assign start_rise = start_s2 & ~start_dly;
    assign start_low  = ~start_s2;
    assign goal       = (player_row == 4'(GOAL_ROW));
    assign cur_score  = turn_q ? p2_score : p1_score;
    // Saturating increment so a score can never pass WIN_SCORE.
    assign cur_inc    = (cur_score == 4'(WIN_SCORE)) ? cur_score : cur_score + 4'd1;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            start_s1      <= 1'b0;
            start_s2      <= 1'b0;
            start_dly     <= 1'b0;
            fsm_q         <= IDLE;
            turn_q        <= 1'b0;
            turn_cnt_q    <= '0;
            freeze_cnt_q  <= '0;
            p1_score      <= '0;
            p2_score      <= '0;
            winner        <= '0;
            state         <= '0;
            obstacle_load <= 1'b0;
            player_reset  <= 1'b0;
            obstacle_step <= 1'b0;
            player_en     <= 1'b0;
        end else begin
            start_s1      <= start;
            start_s2      <= start_s1;
            start_dly     <= start_s2;
            fsm_q         <= fsm_d;
            turn_q        <= turn_d;
            turn_cnt_q    <= turn_cnt_d;
            freeze_cnt_q  <= freeze_cnt_d;
            p1_score      <= p1_d;
            p2_score      <= p2_d;
            winner        <= winner_d;
            state         <= state_d;
            obstacle_load <= load_d;
            player_reset  <= preset_d;
            obstacle_step <= step_d;
            player_en     <= (fsm_d == PLAY);
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        turn_d       = turn_q;
        turn_cnt_d   = turn_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        p1_d         = p1_score;
        p2_d         = p2_score;
        winner_d     = winner;
        load_d       = 1'b0;
        preset_d     = 1'b0;
        step_d       = 1'b0;

        case (fsm_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    fsm_d        = PLAY;
                    turn_d       = 1'b0;
                    turn_cnt_d   = '0;
                    freeze_cnt_d = '0;
                    p1_d         = '0;
                    p2_d         = '0;
                    winner_d     = '0;
                    load_d       = 1'b1;
                    preset_d     = 1'b1;
                end else if (fsm_q == DONE && start_low) begin
                    fsm_d = IDLE;
                end
            end
            PLAY: begin
                // Dropping start outranks every in-play event.
                if (start_low) begin
                    fsm_d = IDLE;
                end else if (hit) begin
                    fsm_d    = FREEZE;
                    preset_d = 1'b1;
                end else if (goal) begin
                    if (turn_q) p2_d = cur_inc;
                    else        p1_d = cur_inc;
                    if (cur_inc == 4'(WIN_SCORE)) begin
                        fsm_d    = DONE;
                        winner_d = turn_q ? 2'b10 : 2'b01;
                    end else begin
                        fsm_d    = FREEZE;
                        preset_d = 1'b1;
                    end
                end else if (tick) begin
                    if (turn_cnt_q == 8'(TURN_TICKS - 1)) begin
                        fsm_d    = FREEZE;
                        preset_d = 1'b1;
                    end else begin
                        turn_cnt_d = turn_cnt_q + 8'd1;
                        step_d     = 1'b1;
                    end
                end
            end
            FREEZE: begin
                // hit and goal are deliberately ignored here, which absorbs a
                // hit that lingers past the player_reset pulse.
                if (start_low) begin
                    fsm_d = IDLE;
                end else if (tick) begin
                    if (freeze_cnt_q == 4'(FREEZE_TICKS - 1)) begin
                        fsm_d        = PLAY;
                        turn_d       = ~turn_q;
                        turn_cnt_d   = '0;
                        freeze_cnt_d = '0;
                    end else begin
                        freeze_cnt_d = freeze_cnt_q + 4'd1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase

        case (fsm_d)
            IDLE:    state_d = 2'b00;
            DONE:    state_d = 2'b11;
            default: state_d = turn_d ? 2'b10 : 2'b01;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a game-rules model compared every
// cycle, directed scenarios with literal expectations, then random play.
module tb_game_sequencer;

    localparam int WIN    = 10;
    localparam int GOAL   = 1;
    localparam int TURN   = 60;
    localparam int FREEZE = 4;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       hit = 1'b0;
    logic [3:0] player_row = 4'd0;
    logic [1:0] state, winner;
    logic [3:0] p1_score, p2_score;
    logic       obstacle_load, player_reset, obstacle_step, player_en;

    int vectors = 0;
    int miscompares = 0;

    game_sequencer #(.WIN_SCORE(WIN), .GOAL_ROW(GOAL), .TURN_TICKS(TURN),
                     .FREEZE_TICKS(FREEZE)) dut (
        .board_clk(board_clk), .reset(reset), .start(start), .tick(tick),
        .hit(hit), .player_row(player_row), .state(state),
        .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
        .obstacle_load(obstacle_load), .player_reset(player_reset),
        .obstacle_step(obstacle_step), .player_en(player_en));

    always #5 board_clk = ~board_clk;

    // ---------------- game-rules model ----------------
    // mode: 0 waiting, 1 playing, 2 frozen, 3 game over
    int m_mode, m_player, m_used, m_frozen;
    int m_score[2];
    int m_winner;
    bit m_load, m_preset, m_step;
    bit hist[3];   // start samples from the last three edges, [0] newest

    task automatic model_reset();
        m_mode = 0; m_player = 1; m_used = 0; m_frozen = 0;
        m_score[0] = 0; m_score[1] = 0; m_winner = 0;
        m_load = 0; m_preset = 0; m_step = 0;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
    endtask

    task automatic model_step(bit s, bit t, bit h, int row);
        bit level, rise;
        level = hist[1];             // start as seen after two sync stages
        rise  = hist[1] && !hist[2];
        m_load = 0; m_preset = 0; m_step = 0;
        if ((m_mode == 0 || m_mode == 3) && rise) begin
            m_mode = 1; m_player = 1; m_used = 0; m_frozen = 0;
            m_score[0] = 0; m_score[1] = 0; m_winner = 0;
            m_load = 1; m_preset = 1;
        end else if (m_mode != 0 && !level) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (h) begin
                m_mode = 2; m_frozen = 0; m_preset = 1;
            end else if (row == GOAL) begin
                if (m_score[m_player-1] < WIN) m_score[m_player-1]++;
                if (m_score[m_player-1] == WIN) begin
                    m_mode = 3; m_winner = m_player;
                end else begin
                    m_mode = 2; m_frozen = 0; m_preset = 1;
                end
            end else if (t) begin
                m_used++;
                if (m_used == TURN) begin
                    m_mode = 2; m_frozen = 0; m_preset = 1;
                end else begin
                    m_step = 1;
                end
            end
        end else if (m_mode == 2 && t) begin
            m_frozen++;
            if (m_frozen == FREEZE) begin
                m_mode = 1; m_used = 0; m_frozen = 0;
                m_player = 3 - m_player;
            end
        end
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
    endtask

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 3) return 3;
        return m_player;
    endfunction

    initial model_reset();

    // compare process: model advances on each edge, DUT checked 1 time unit later
    always @(posedge board_clk) begin
        if (reset) model_reset();
        else model_step(start, tick, hit, int'(player_row));
        #1;
        vectors++;
        if (int'(state) != exp_state() || int'(p1_score) != m_score[0] ||
            int'(p2_score) != m_score[1] || int'(winner) != m_winner ||
            obstacle_load != m_load || player_reset != m_preset ||
            obstacle_step != m_step || player_en != (m_mode == 1)) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got st=%0d p1=%0d p2=%0d w=%0d ld=%0b pr=%0b os=%0b en=%0b, want st=%0d p1=%0d p2=%0d w=%0d ld=%0b pr=%0b os=%0b en=%0b",
                     $time, state, p1_score, p2_score, winner, obstacle_load,
                     player_reset, obstacle_step, player_en, exp_state(),
                     m_score[0], m_score[1], m_winner, m_load, m_preset,
                     m_step, m_mode == 1);
        end
    end

    // ---------------- driver ----------------
    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge board_clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_goal();
        player_row = 4'(GOAL);
        step();
        player_row = 4'd0;
    endtask

    task automatic do_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    initial begin
        int cnt, rcnt;
        repeat (3) step();
        chk("reset_state", int'(state), 0);
        chk("reset_pulses", int'({obstacle_load, player_reset, obstacle_step, player_en}), 0);
        reset = 1'b0;
        step();

        // start latency: state moves on the 3rd edge
        start = 1'b1;
        step(); step();
        chk("start_latency_early", int'(state), 0);
        step();
        chk("start_state", int'(state), 1);
        chk("start_load", int'(obstacle_load), 1);
        chk("start_preset", int'(player_reset), 1);
        chk("start_en", int'(player_en), 1);
        step();
        chk("load_one_cycle", int'(obstacle_load), 0);

        // player 1 goal, then freeze of 4 ticks with no obstacle steps
        do_goal();
        chk("goal_p1_score", int'(p1_score), 1);
        chk("goal_preset", int'(player_reset), 1);
        cnt = 0;
        for (int i = 0; i < FREEZE; i++) begin
            do_tick();
            cnt += int'(obstacle_step);
            if (i == FREEZE - 2) chk("freeze_hold_turn", int'(state), 1);
        end
        chk("freeze_no_step", cnt, 0);
        chk("turn_to_p2", int'(state), 2);

        // hit and goal together: hit wins, no score
        hit = 1'b1; player_row = 4'(GOAL);
        step();
        hit = 1'b0; player_row = 4'd0;
        chk("hitgoal_p2", int'(p2_score), 0);
        chk("hitgoal_p1", int'(p1_score), 1);
        chk("hitgoal_preset", int'(player_reset), 1);
        ticks(FREEZE);
        chk("hitgoal_turn", int'(state), 1);

        // timeout after TURN ticks
        cnt = 0;
        for (int i = 0; i < TURN; i++) begin
            do_tick();
            cnt += int'(obstacle_step);
        end
        chk("timeout_steps", cnt, TURN - 1);
        chk("timeout_preset", int'(player_reset), 1);
        ticks(FREEZE);
        chk("timeout_turn", int'(state), 2);

        // drive p2 to WIN-1 (p1 turns end with hits)
        for (int i = 0; i < WIN - 1; i++) begin
            do_goal();
            ticks(FREEZE);
            do_hit();
            ticks(FREEZE);
        end
        chk("p2_nine", int'(p2_score), WIN - 1);
        do_goal();
        chk("win_p2", int'(p2_score), WIN);
        chk("win_state", int'(state), 3);
        chk("win_winner", int'(winner), 2);
        chk("win_en", int'(player_en), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            cnt += int'(obstacle_step) + int'(player_reset);
        end
        chk("done_no_pulses", cnt, 0);

        // start low from DONE, then restart
        start = 1'b0;
        step(); step(); step();
        chk("drop_done_state", int'(state), 0);
        chk("drop_done_hold", int'(p2_score), WIN);
        chk("drop_done_winner", int'(winner), 2);
        start = 1'b1;
        step(); step(); step();
        chk("restart_state", int'(state), 1);
        chk("restart_scores", int'({p1_score, p2_score, 2'b00, winner}), 0);

        // start dropped mid-turn
        do_goal();
        ticks(FREEZE);
        ticks(3);
        start = 1'b0;
        step(); step();
        chk("drop_mid_latency", int'(state), 2);
        step();
        chk("drop_mid_state", int'(state), 0);
        chk("drop_mid_hold", int'(p1_score), 1);
        start = 1'b1;
        step(); step(); step();
        chk("restart2_p1", int'(p1_score), 0);
        ticks(5);

        // asynchronous reset mid-game
        #3 reset = 1'b1;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_score", int'(p1_score), 0);
        step(); step();
        reset = 1'b0;

        // random play
        rcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            hit = ($urandom_range(0, 11) == 0);
            player_row = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 249) == 0) start = ~start;
            step();
            rcnt += int'(obstacle_load);
        end
        tick = 1'b0; hit = 1'b0; player_row = 4'd0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
